morse_char_seq: RTL

Character-level sequencer sitting directly upstream of `led_fsm` in the Morse encoder. It accepts one encoded character and its symbol count from the ASCII-to-Morse lookup, then issues the symbols to `led_fsm` one at a time, MSB first, through the `sym_strt`/`sym`/`sym_done` handshake. It signals completion to the text-level controller above it.

---
 rtl/morse_pkg.sv | 6 +
 rtl/morse_char_seq.sv | 94 +++++++++
 2 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: state encoding and sizing constants shared by the Morse encoder blocks
package morse_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_t;
  localparam int MORSE_MAXLEN    = 8;
  localparam int CHAR_GAP_CYCLES = 3;
endpackage

// File: rtl/morse_char_seq.sv
// morse_char_seq: issues one character's symbols MSB first to led_fsm.
// Define MORSE_CHAR_GAP_EN to add a CHAR_GAP_CYCLES idle gap before char_done.
module morse_char_seq
  import morse_pkg::*;
#(
  parameter int MAXLEN = MORSE_MAXLEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              char_strt,
  input  logic [MAXLEN-1:0] charcode,
  input  logic [3:0]        charlen,
  input  logic              sym_done,
  output logic              sym_strt,
  output logic              sym,
  output logic              busy,
  output logic              char_done
);
`ifdef MORSE_CHAR_GAP_EN
  localparam state_t S_AFTER = S_GAP;
`else
  localparam state_t S_AFTER = S_DONE;
`endif
  state_t            r_state, w_state_nx;
  logic [MAXLEN-1:0] r_shreg, w_shreg_nx;
  logic [3:0]        r_cnt, w_cnt_nx;
  logic [3:0]        w_len;
  logic              r_sym_strt, r_sym, r_busy, r_char_done;
  logic              w_sym_nx;
`ifdef MORSE_CHAR_GAP_EN
  logic [1:0]        r_gap, w_gap_nx;
`endif
  assign w_len    = (charlen > 4'(MAXLEN)) ? 4'(MAXLEN) : charlen;
  // sym is forced low outside a symbol so leftover code bits never leak out
  assign w_sym_nx = (w_state_nx == S_ISSUE || w_state_nx == S_WAIT) & w_shreg_nx[MAXLEN-1];
  always_comb begin
    w_state_nx = r_state;
    w_shreg_nx = r_shreg;
    w_cnt_nx   = r_cnt;
`ifdef MORSE_CHAR_GAP_EN
    w_gap_nx   = r_gap;
`endif
    case (r_state)
      S_IDLE: if (char_strt) begin
        w_shreg_nx = charcode;
        w_cnt_nx   = w_len;
        w_state_nx = (w_len == 4'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: w_state_nx = S_WAIT;
      S_WAIT: if (sym_done) begin
        w_shreg_nx = r_shreg << 1;
        w_cnt_nx   = (r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
        w_state_nx = (r_cnt <= 4'd1) ? S_AFTER : S_ISSUE;
      end
`ifdef MORSE_CHAR_GAP_EN
      S_GAP: begin
        w_gap_nx   = (r_gap == 2'(CHAR_GAP_CYCLES - 1)) ? 2'd0 : r_gap + 2'd1;
        w_state_nx = (r_gap == 2'(CHAR_GAP_CYCLES - 1)) ? S_DONE : S_GAP;
      end
`endif
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_sym_strt  <= 1'b0;
      r_sym       <= 1'b0;
      r_busy      <= 1'b0;
      r_char_done <= 1'b0;
`ifdef MORSE_CHAR_GAP_EN
      r_gap       <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_shreg     <= w_shreg_nx;
      r_cnt       <= w_cnt_nx;
      r_sym_strt  <= (w_state_nx == S_ISSUE);
      r_sym       <= w_sym_nx;
      r_busy      <= (w_state_nx != S_IDLE);
      r_char_done <= (w_state_nx == S_DONE);
`ifdef MORSE_CHAR_GAP_EN
      r_gap       <= w_gap_nx;
`endif
    end
  end
  assign sym_strt  = r_sym_strt;
  assign sym       = r_sym;
  assign busy      = r_busy;
  assign char_done = r_char_done;
endmodule
